mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access as a multi-cycle request/acknowledge transaction.
- Generates the stall controls that freeze the pipeline while an access is outstanding.
- Sits beside the hazard stall unit; its stall outputs are ORed with the load-use stall at the PC and IF/ID write enables.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_watchdog.sv | 38 +++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int AW_DEF       = 32;
    localparam int DW_DEF       = 32;
    localparam int MAX_WAIT_DEF = 64;
    localparam int WD_W         = 8;   // watchdog counter width, covers MAX_WAIT up to 255

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_ACC = 2'd1,
        ST_DM_ACC = 2'd2,
        ST_RESP   = 2'd3
    } arbState_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts cycles an access is outstanding and flags an abort.
// Latency: timeout is combinational in the cycle the count would reach MAX_WAIT.
// Backpressure: none; clear has priority over enable.
//
// Ports:
//   CLK, Reset  - clock and synchronous active-high reset
//   clear       - zero the count (asserted on grant)
//   enable      - count this cycle (asserted while an access is outstanding)
//   timeout     - this is the MAX_WAIT-th outstanding cycle without completion
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [WD_W-1:0] waitCount;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            waitCount <= '0;
        end else if (clear) begin
            waitCount <= '0;
        end else if (enable && (waitCount != WD_W'(MAX_WAIT))) begin
            waitCount <= waitCount + WD_W'(1);
        end
    end

    // Fires during the cycle whose closing edge takes the count to MAX_WAIT,
    // so an access gets exactly MAX_WAIT outstanding cycles before abort.
    assign timeout = enable && (waitCount == WD_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Latency: grant edge + memory ack latency + one response cycle (3 cycles minimum).
// Backpressure: requesters hold until their Done pulse; stall outputs freeze the pipe.
//
// Ports:
//   CLK, Reset                         - clock, synchronous active-high reset
//   IF_Req/IF_Addr -> IF_Instr/IF_Done - fetch request and completion
//   DM_Read/DM_Write/DM_Addr/DM_WData  - data request; DM_RData/DM_Done completion
//   Mem_Req/Mem_WE/Mem_Addr/Mem_WData  - memory request (held until Mem_Ack)
//   Mem_Ack/Mem_RData                  - memory completion and read data
//   Pipe_Stall, Fetch_Stall            - pipeline freeze controls
//   Err_Timeout                        - sticky watchdog abort flag
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          IF_Req,
    input  logic [AW-1:0] IF_Addr,
    output logic [DW-1:0] IF_Instr,
    output logic          IF_Done,
    input  logic          DM_Read,
    input  logic          DM_Write,
    input  logic [AW-1:0] DM_Addr,
    input  logic [DW-1:0] DM_WData,
    output logic [DW-1:0] DM_RData,
    output logic          DM_Done,
    output logic          Mem_Req,
    output logic          Mem_WE,
    output logic [AW-1:0] Mem_Addr,
    output logic [DW-1:0] Mem_WData,
    input  logic          Mem_Ack,
    input  logic [DW-1:0] Mem_RData,
    output logic          Pipe_Stall,
    output logic          Fetch_Stall,
    output logic          Err_Timeout
);

    arbState_t state;
    logic      fairIf;     // last completed access was DM: IF wins the next contested grant
    logic      dmReq;
    logic      grantDm;
    logic      grantIf;
    logic      inAcc;
    logic      wdTimeout;
    logic      accEnd;

    assign dmReq   = DM_Read | DM_Write;
    assign grantDm = (state == ST_IDLE) && dmReq && !(fairIf && IF_Req);
    assign grantIf = (state == ST_IDLE) && IF_Req && !grantDm;
    assign inAcc   = (state == ST_IF_ACC) || (state == ST_DM_ACC);
    // Ack and timeout on the same edge: the ack wins and the data is kept.
    assign accEnd  = inAcc && (Mem_Ack || wdTimeout);

    mem_arb_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .CLK     (CLK),
        .Reset   (Reset),
        .clear   (grantDm | grantIf),
        .enable  (inAcc),
        .timeout (wdTimeout)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= ST_IDLE;
            fairIf      <= 1'b0;
            Mem_Req     <= 1'b0;
            Mem_WE      <= 1'b0;
            Mem_Addr    <= '0;
            Mem_WData   <= '0;
            IF_Instr    <= '0;
            DM_RData    <= '0;
            IF_Done     <= 1'b0;
            DM_Done     <= 1'b0;
            Err_Timeout <= 1'b0;
        end else begin
            IF_Done <= 1'b0;
            DM_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grantDm) begin
                        state     <= ST_DM_ACC;
                        Mem_Req   <= 1'b1;
                        Mem_WE    <= DM_Write;   // read+write together acts as a store
                        Mem_Addr  <= DM_Addr;
                        Mem_WData <= DM_WData;
                    end else if (grantIf) begin
                        state     <= ST_IF_ACC;
                        Mem_Req   <= 1'b1;
                        Mem_WE    <= 1'b0;
                        Mem_Addr  <= IF_Addr;
                        Mem_WData <= '0;
                        fairIf    <= 1'b0;
                    end
                end
                ST_IF_ACC: begin
                    if (accEnd) begin
                        state    <= ST_RESP;
                        Mem_Req  <= 1'b0;
                        IF_Done  <= 1'b1;
                        IF_Instr <= Mem_Ack ? Mem_RData : '0;
                        if (!Mem_Ack) begin
                            Err_Timeout <= 1'b1;
                        end
                    end
                end
                ST_DM_ACC: begin
                    if (accEnd) begin
                        state    <= ST_RESP;
                        Mem_Req  <= 1'b0;
                        DM_Done  <= 1'b1;
                        DM_RData <= (Mem_Ack && !Mem_WE) ? Mem_RData : '0;
                        fairIf   <= 1'b1;
                        if (!Mem_Ack) begin
                            Err_Timeout <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    // No arbitration here, so a request still held during its
                    // own completion cycle is not granted a second time.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Pipe_Stall  = dmReq & ~DM_Done;
    assign Fetch_Stall = Pipe_Stall | (IF_Req & ~IF_Done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a delayed-ack memory model.
// Latency: n/a.
// Backpressure: requester models hold requests until Done.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          IF_Req;
    logic [AW-1:0] IF_Addr;
    logic [DW-1:0] IF_Instr;
    logic          IF_Done;
    logic          DM_Read;
    logic          DM_Write;
    logic [AW-1:0] DM_Addr;
    logic [DW-1:0] DM_WData;
    logic [DW-1:0] DM_RData;
    logic          DM_Done;
    logic          Mem_Req;
    logic          Mem_WE;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_WData;
    logic          Mem_Ack;
    logic [DW-1:0] Mem_RData;
    logic          Pipe_Stall;
    logic          Fetch_Stall;
    logic          Err_Timeout;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .Reset(Reset),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Instr(IF_Instr), .IF_Done(IF_Done),
        .DM_Read(DM_Read), .DM_Write(DM_Write), .DM_Addr(DM_Addr), .DM_WData(DM_WData),
        .DM_RData(DM_RData), .DM_Done(DM_Done),
        .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData),
        .Pipe_Stall(Pipe_Stall), .Fetch_Stall(Fetch_Stall), .Err_Timeout(Err_Timeout)
    );

    // Memory model: ack in the ackDelay-th cycle of Mem_Req (0 = never).
    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    int   ackDelay = 2;
    logic ackForce = 1'b0;
    int   reqAge = 0;
    always @(posedge CLK) reqAge <= (Mem_Req && !Mem_Ack) ? reqAge + 1 : 0;
    assign Mem_Ack   = ackForce || (Mem_Req && (ackDelay != 0) && (reqAge == ackDelay - 1));
    assign Mem_RData = memData(Mem_Addr);

    typedef struct {logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata;} dmOp_t;
    typedef struct {logic isDm; logic we; logic [31:0] addr; logic [31:0] wdata;} grant_t;
    typedef struct {
        logic isDm; logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata;
        int delay; int expReqCyc; int expDoneCyc; logic expWe; logic expErr;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [31:0] ifExpQ[$];
    logic [31:0] dmExpQ[$];
    logic [31:0] ifPend[$];
    dmOp_t       dmPend[$];
    grant_t      grantQ[$];
    logic ifDoneSeen, dmDoneSeen, prevReq, expectTo;
    int doneCount = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic startIf(input logic [31:0] a);
        IF_Req  = 1'b1;
        IF_Addr = a;
        ifExpQ.push_back(expectTo ? 32'h0 : memData(a));
    endtask

    task automatic startDm(input dmOp_t op);
        DM_Read  = op.rd;
        DM_Write = op.wr;
        DM_Addr  = op.addr;
        DM_WData = op.wdata;
        dmExpQ.push_back((op.wr || expectTo) ? 32'h0 : memData(op.addr));
    endtask

    // Sample half: scoreboard compare on Done, grant logging, address stability.
    task automatic sampleHalf();
        grant_t g;
        @(negedge CLK);
        ifDoneSeen = IF_Done;
        dmDoneSeen = DM_Done;
        doneCount += int'(IF_Done) + int'(DM_Done);
        if (IF_Done) begin
            if (ifExpQ.size() == 0) check("if_unexpected_done", 1, 0);
            else check("if_instr", IF_Instr, ifExpQ.pop_front());
        end
        if (DM_Done) begin
            if (dmExpQ.size() == 0) check("dm_unexpected_done", 1, 0);
            else check("dm_rdata", DM_RData, dmExpQ.pop_front());
        end
        if (Mem_Req && !prevReq) begin
            g.isDm  = (Mem_Addr[31:28] == 4'h1);
            g.we    = Mem_WE;
            g.addr  = Mem_Addr;
            g.wdata = Mem_WData;
            grantQ.push_back(g);
        end else if (Mem_Req && prevReq && grantQ.size() > 0) begin
            check("mem_addr_stable", Mem_Addr, grantQ[$].addr);
        end
        prevReq = Mem_Req;
    endtask

    // Drive half: requesters drop or advance after their Done cycle.
    task automatic driveHalf();
        @(posedge CLK);
        #1;
        if (ifDoneSeen) begin
            if (ifPend.size() > 0) startIf(ifPend.pop_front());
            else IF_Req = 1'b0;
        end
        if (dmDoneSeen) begin
            if (dmPend.size() > 0) startDm(dmPend.pop_front());
            else begin DM_Read = 1'b0; DM_Write = 1'b0; end
        end
        ifDoneSeen = 1'b0;
        dmDoneSeen = 1'b0;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        IF_Req = 1'b0; IF_Addr = '0;
        DM_Read = 1'b0; DM_Write = 1'b0; DM_Addr = '0; DM_WData = '0;
        ackForce = 1'b0; expectTo = 1'b0;
        ifExpQ.delete(); dmExpQ.delete(); ifPend.delete(); dmPend.delete(); grantQ.delete();
        ifDoneSeen = 1'b0; dmDoneSeen = 1'b0; prevReq = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ctrl"}, {Mem_Req, Mem_WE, IF_Done, DM_Done, Err_Timeout, Pipe_Stall, Fetch_Stall}, 0);
        check({tag, "_addr"}, Mem_Addr, 0);
        check({tag, "_wdata"}, Mem_WData, 0);
        check({tag, "_instr"}, IF_Instr, 0);
        check({tag, "_rdata"}, DM_RData, 0);
    endtask

    task automatic runDrain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ifExpQ.size() == 0 && dmExpQ.size() == 0 && !IF_Req && !DM_Read && !DM_Write) break;
            sampleHalf();
            driveHalf();
        end
        check("drain_pending", ifExpQ.size() + dmExpQ.size() + ifPend.size() + dmPend.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t vecs[8];
        int reqCyc, doneCyc, cnt0;
        vecs[0] = '{0, 0, 0, 32'h0040_0000, 32'h0,         2, 2, 3, 0, 0};
        vecs[1] = '{0, 0, 0, 32'h0040_0004, 32'h0,         1, 1, 2, 0, 0};
        vecs[2] = '{1, 1, 0, 32'h1001_0004, 32'h0,         3, 3, 4, 0, 0};
        vecs[3] = '{1, 0, 1, 32'h1001_0000, 32'hDEADBEEF,  2, 2, 3, 1, 0};
        vecs[4] = '{1, 1, 1, 32'h1001_0010, 32'h1234_5678, 1, 1, 2, 1, 0};
        vecs[5] = '{1, 1, 0, 32'h1001_0020, 32'h0,         4, 4, 5, 0, 0};
        vecs[6] = '{1, 1, 0, 32'h1001_0030, 32'h0,         0, 4, 5, 0, 1};
        vecs[7] = '{0, 0, 0, 32'h0040_0100, 32'h0,         0, 4, 5, 0, 1};

        // Reset values
        doReset();
        sampleHalf();
        checkResetOutputs("reset");
        driveHalf();

        // Single-transaction vectors
        for (int v = 0; v < 8; v++) begin
            doReset();
            check("err_after_reset", Err_Timeout, 0);
            ackDelay = vecs[v].delay;
            expectTo = (vecs[v].delay == 0);
            if (vecs[v].isDm) startDm('{vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata});
            else startIf(vecs[v].addr);
            reqCyc = 0;
            doneCyc = -1;
            for (int c = 0; c < 12; c++) begin
                sampleHalf();
                if (c == 0) begin
                    check("pipe_stall_req", Pipe_Stall, vecs[v].isDm);
                    check("fetch_stall_req", Fetch_Stall, 1);
                end
                if (Mem_Req) begin
                    reqCyc++;
                    if (reqCyc == 1) begin
                        check("mem_we", Mem_WE, vecs[v].expWe);
                        check("mem_addr", Mem_Addr, vecs[v].addr);
                        if (vecs[v].isDm && vecs[v].wr) check("mem_wdata", Mem_WData, vecs[v].wdata);
                    end
                end
                if (IF_Done || DM_Done) begin
                    doneCyc = c;
                    check("done_port", DM_Done, vecs[v].isDm);
                    check("fetch_stall_done", Fetch_Stall, 0);
                    check("pipe_stall_done", Pipe_Stall, 0);
                end
                if (doneCyc >= 0 && c == doneCyc + 1) check("no_reissue", Mem_Req, 0);
                driveHalf();
            end
            check("req_cycles", reqCyc, vecs[v].expReqCyc);
            check("done_cycle", doneCyc, vecs[v].expDoneCyc);
            check("err_timeout", Err_Timeout, vecs[v].expErr);
            check("vec_drained", ifExpQ.size() + dmExpQ.size(), 0);
        end

        // Store and fetch together, then a new load: DM, IF (fairness), DM
        doReset();
        ackDelay = 2;
        startDm('{1'b0, 1'b1, 32'h1001_0000, 32'hDEADBEEF});
        startIf(32'h0040_0000);
        dmPend.push_back('{1'b1, 1'b0, 32'h1001_0008, 32'h0});
        runDrain(60);
        check("fair_grants", grantQ.size(), 3);
        if (grantQ.size() == 3) begin
            check("fair_g0_dm", grantQ[0].isDm, 1);
            check("fair_g0_we", grantQ[0].we, 1);
            check("fair_g0_wdata", grantQ[0].wdata, 32'hDEADBEEF);
            check("fair_g1_if", grantQ[1].isDm, 0);
            check("fair_g2_dm", grantQ[2].isDm, 1);
            check("fair_g2_addr", grantQ[2].addr, 32'h1001_0008);
        end

        // Back-to-back loads with fetch pending: grants alternate
        doReset();
        ackDelay = 1;
        startDm('{1'b1, 1'b0, 32'h1001_0100, 32'h0});
        startIf(32'h0040_0200);
        for (int i = 1; i < 4; i++) begin
            dmPend.push_back('{1'b1, 1'b0, 32'h1001_0100 + 32'(4 * i), 32'h0});
            ifPend.push_back(32'h0040_0200 + 32'(4 * i));
        end
        runDrain(80);
        check("alt_grants", grantQ.size(), 8);
        for (int i = 0; i < 8 && i < grantQ.size(); i++)
            check($sformatf("alt_g%0d", i), grantQ[i].isDm, (i % 2) == 0);

        // Reset the cycle after a grant, then a late ack
        doReset();
        ackDelay = 0;
        startDm('{1'b1, 1'b0, 32'h1001_0200, 32'h0});
        sampleHalf();
        driveHalf();
        Reset = 1'b1;
        sampleHalf();
        check("rstmid_req_before", Mem_Req, 1);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        DM_Read = 1'b0;
        dmExpQ.delete();
        sampleHalf();
        checkResetOutputs("rstmid");
        driveHalf();
        ackForce = 1'b1;
        cnt0 = doneCount;
        sampleHalf();
        driveHalf();
        ackForce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sampleHalf();
            driveHalf();
        end
        check("rstmid_no_done", doneCount - cnt0, 0);
        check("rstmid_no_req", Mem_Req, 0);

        // Spurious ack in IDLE
        doReset();
        sampleHalf();
        driveHalf();
        ackForce = 1'b1;
        cnt0 = doneCount;
        sampleHalf();
        check("spur_no_req", Mem_Req, 0);
        driveHalf();
        ackForce = 1'b0;
        sampleHalf();
        check("spur_no_done", doneCount - cnt0, 0);
        check("spur_idle_req", Mem_Req, 0);
        driveHalf();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
